// File: rtl/nh_lcd_data_reader_if.sv
// FIFO write port and 8080-style LCD bus shared by the NH LCD read-back engine.
// master = reader side, slave = FIFO/panel side.
interface nh_lcd_data_reader_if;
    logic [1:0]  o_fifo_rdy;
    logic [1:0]  o_fifo_act;
    logic [23:0] i_fifo_size;
    logic        o_fifo_stb;
    logic [24:0] o_fifo_data;
    logic        o_cmd_mode;
    logic [7:0]  o_data_out;
    logic [7:0]  i_data_in;
    logic        o_write;
    logic        o_read;
    logic        o_data_out_en;

    modport master (
        input  o_fifo_rdy, i_fifo_size, i_data_in,
        output o_fifo_act, o_fifo_stb, o_fifo_data,
        output o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
    );

    modport slave (
        output o_fifo_rdy, i_fifo_size, i_data_in,
        input  o_fifo_act, o_fifo_stb, o_fifo_data,
        input  o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en
    );
endinterface

// File: rtl/nh_lcd_data_reader.sv
// NH LCD frame read-back: issues the memory-read command, skips the dummy byte and
// streams 24-bit pixels into a ping-pong FIFO. NH_LCD_READER_BGR_EN selects B,G,R byte order.
module nh_lcd_data_reader #(
    parameter int unsigned READ_CYCLES  = 4,
    parameter int unsigned IDLE_CYCLES  = 1,
    parameter logic [7:0]  CMD_READ_MEM = 8'h2E
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_enable,
    input  logic                        i_start,
    input  logic [31:0]                 i_image_width,
    input  logic [31:0]                 i_image_height,
    output logic                        o_busy,
    output logic                        o_done,
    nh_lcd_data_reader_if.master        bus
);

    localparam logic [15:0] RD_LAST   = 16'(READ_CYCLES - 1);
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_CMD_HOLD, ST_DUMMY, ST_GET_FIFO,
        ST_RD_R, ST_RD_G, ST_RD_B, ST_PUSH, ST_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_cyc;
    logic [31:0] r_pixel_x;
    logic [31:0] r_line_y;
    logic [23:0] r_word_cnt;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [7:0]  r_byte2;
    logic        r_busy;
    logic        r_done;
    logic [1:0]  r_fifo_act;
    logic        r_fifo_stb;
    logic [24:0] r_fifo_data;
    logic        r_cmd_mode;
    logic [7:0]  r_data_out;
    logic        r_write;
    logic        r_read;
    logic        r_data_out_en;

    logic w_last_x;
    logic w_last_pixel;
    logic w_word_full;
    logic w_zero_size;

    function automatic logic [24:0] f_pack(input logic last, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2);
`ifdef NH_LCD_READER_BGR_EN
        f_pack = {last, b2, b1, b0};
`else
        f_pack = {last, b0, b1, b2};
`endif
    endfunction

    assign w_last_x     = (r_pixel_x == (i_image_width - 32'd1));
    assign w_last_pixel = w_last_x && (r_line_y == (i_image_height - 32'd1));
    assign w_word_full  = ((r_word_cnt + 24'd1) == bus.i_fifo_size);
    assign w_zero_size  = (i_image_width == 32'd0) || (i_image_height == 32'd0);

    // Frame sequencer: command phase, byte-read timing, FIFO grant and pixel push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cyc         <= 16'd0;
            r_pixel_x     <= 32'd0;
            r_line_y      <= 32'd0;
            r_word_cnt    <= 24'd0;
            r_byte0       <= 8'd0;
            r_byte1       <= 8'd0;
            r_byte2       <= 8'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fifo_act    <= 2'b00;
            r_fifo_stb    <= 1'b0;
            r_fifo_data   <= 25'd0;
            r_cmd_mode    <= 1'b1;
            r_data_out    <= CMD_READ_MEM;
            r_write       <= 1'b0;
            r_read        <= 1'b0;
            r_data_out_en <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start && i_enable) begin
                        r_busy     <= 1'b1;
                        r_pixel_x  <= 32'd0;
                        r_line_y   <= 32'd0;
                        r_word_cnt <= 24'd0;
                        if (w_zero_size) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cmd_mode <= 1'b0;
                            r_write    <= 1'b1;
                            r_data_out <= CMD_READ_MEM;
                            r_state    <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    r_write <= 1'b0;
                    r_state <= ST_CMD_HOLD;
                end
                ST_CMD_HOLD: begin
                    r_data_out_en <= 1'b0;
                    r_cmd_mode    <= 1'b1;
                    r_read        <= 1'b1;
                    r_cyc         <= 16'd0;
                    r_state       <= ST_DUMMY;
                end
                ST_GET_FIFO: begin
                    if (!i_enable) begin
                        r_fifo_act    <= 2'b00;
                        r_data_out_en <= 1'b1;
                        r_state       <= ST_DONE;
                    end else if (r_fifo_act != 2'b00) begin
                        r_read  <= 1'b1;
                        r_cyc   <= 16'd0;
                        r_state <= ST_RD_R;
                    end else if (bus.o_fifo_rdy != 2'b00) begin
                        r_fifo_act <= bus.o_fifo_rdy[0] ? 2'b01 : 2'b10;
                        r_word_cnt <= 24'd0;
                        r_read     <= 1'b1;
                        r_cyc      <= 16'd0;
                        r_state    <= ST_RD_R;
                    end
                end
                // Each byte: READ_CYCLES clocks high (capture on the last), then IDLE_CYCLES low.
                ST_DUMMY, ST_RD_R, ST_RD_G, ST_RD_B: begin
                    if (r_read) begin
                        if (r_cyc == RD_LAST) begin
                            r_read <= 1'b0;
                            r_cyc  <= 16'd0;
                            case (r_state)
                                ST_RD_R: r_byte0 <= bus.i_data_in;
                                ST_RD_G: r_byte1 <= bus.i_data_in;
                                ST_RD_B: r_byte2 <= bus.i_data_in;
                                default: ;
                            endcase
                        end else begin
                            r_cyc <= r_cyc + 16'd1;
                        end
                    end else if (r_cyc == IDLE_LAST) begin
                        r_cyc <= 16'd0;
                        case (r_state)
                            ST_DUMMY: r_state <= ST_GET_FIFO;
                            ST_RD_R: begin
                                r_read  <= 1'b1;
                                r_state <= ST_RD_G;
                            end
                            ST_RD_G: begin
                                r_read  <= 1'b1;
                                r_state <= ST_RD_B;
                            end
                            default: begin
                                r_fifo_stb  <= 1'b1;
                                r_fifo_data <= f_pack(w_last_x, r_byte0, r_byte1, r_byte2);
                                r_state     <= ST_PUSH;
                            end
                        endcase
                    end else begin
                        r_cyc <= r_cyc + 16'd1;
                    end
                end
                ST_PUSH: begin
                    r_fifo_stb <= 1'b0;
                    if (w_last_x) begin
                        r_pixel_x <= 32'd0;
                        r_line_y  <= r_line_y + 32'd1;
                    end else begin
                        r_pixel_x <= r_pixel_x + 32'd1;
                    end
                    if (w_last_pixel || !i_enable) begin
                        r_fifo_act    <= 2'b00;
                        r_data_out_en <= 1'b1;
                        r_done        <= w_last_pixel;
                        r_state       <= ST_DONE;
                    end else begin
                        if (w_word_full) begin
                            r_fifo_act <= 2'b00;
                            r_word_cnt <= 24'd0;
                        end else begin
                            r_word_cnt <= r_word_cnt + 24'd1;
                        end
                        r_state <= ST_GET_FIFO;
                    end
                end
                ST_DONE: begin
                    r_done        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_data_out_en <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign bus.o_fifo_act    = r_fifo_act;
    assign bus.o_fifo_stb    = r_fifo_stb;
    assign bus.o_fifo_data   = r_fifo_data;
    assign bus.o_cmd_mode    = r_cmd_mode;
    assign bus.o_data_out    = r_data_out;
    assign bus.o_write       = r_write;
    assign bus.o_read        = r_read;
    assign bus.o_data_out_en = r_data_out_en;

endmodule

// File: tb/tb_nh_lcd_data_reader.sv
// Self-checking bench for nh_lcd_data_reader: panel/FIFO models drive the bus, a
// reference model derives expected pixels, grabs and strobe counts from frame geometry.
module tb_nh_lcd_data_reader;
    localparam int RC = 3;
    localparam int IC = 2;

    logic        clk = 1'b0;
    logic        rst, enable, start, busy, done;
    logic [31:0] width, height;

    nh_lcd_data_reader_if bus();

    nh_lcd_data_reader #(.READ_CYCLES(RC), .IDLE_CYCLES(IC), .CMD_READ_MEM(8'h2E)) dut (
        .clk(clk), .rst(rst), .i_enable(enable), .i_start(start),
        .i_image_width(width), .i_image_height(height),
        .o_busy(busy), .o_done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  panel_q[$];
    logic [24:0] got_q[$];
    int          grab_q[$];
    int hi_cnt = 0, lo_cnt = 0, read_rises = 0, read_noact = 0, writes = 0, dones = 0;
    int strobes_grab = 0;
    int viol_len = 0, viol_gap = 0, viol_stb = 0, viol_act = 0, viol_sel = 0, viol_cmd = 0, viol_en = 0;
    int rdy_mode = 0;
    logic [1:0] rdy_fixed = 2'b01;
    bit  alt = 1'b0;
    int  stall = 0;
    logic prev_read = 1'b0;
    logic [1:0] prev_act = 2'b00, prev_rdy = 2'b00;

    // Panel and FIFO-side model: observe the DUT, then drive the next bus/ready values.
    always @(negedge clk) begin
        if (bus.o_read) begin
            if (!prev_read) begin
                if (read_rises > 0 && lo_cnt < IC) viol_gap++;
                if (read_rises > 0 && ((read_rises - 1) % 3) != 0 && lo_cnt != IC) viol_gap++;
                if (bus.o_fifo_act == 2'b00) read_noact++;
                read_rises++;
                lo_cnt = 0;
            end
            hi_cnt++;
            if (bus.o_data_out_en) viol_en++;
        end else begin
            if (prev_read && hi_cnt != RC) viol_len++;
            hi_cnt = 0;
            lo_cnt++;
        end
        if (bus.o_fifo_stb) begin
            got_q.push_back(bus.o_fifo_data);
            strobes_grab++;
            if (bus.o_fifo_act == 2'b00) viol_stb++;
        end
        if (bus.o_fifo_act == 2'b11) viol_act++;
        if (bus.o_fifo_act != 2'b00 && prev_act == 2'b00)
            if (bus.o_fifo_act != (prev_rdy[0] ? 2'b01 : 2'b10)) viol_sel++;
        if (bus.o_fifo_act == 2'b00 && prev_act != 2'b00) begin
            grab_q.push_back(strobes_grab);
            strobes_grab = 0;
        end
        if (bus.o_write) begin
            writes++;
            if (bus.o_data_out != 8'h2E || bus.o_cmd_mode != 1'b0) viol_cmd++;
        end
        if (done) dones++;

        if (bus.o_read && hi_cnt == RC)
            bus.i_data_in = (panel_q.size() > 0) ? panel_q.pop_front() : 8'hEE;
        else
            bus.i_data_in = 8'($urandom);

        if (rdy_mode == 0) begin
            bus.o_fifo_rdy = rdy_fixed;
        end else if (bus.o_fifo_act != 2'b00) begin
            bus.o_fifo_rdy = 2'b00;
            if (prev_act == 2'b00) begin
                alt   = !alt;
                stall = int'($urandom_range(1, 5));
            end
        end else if (stall > 0) begin
            bus.o_fifo_rdy = 2'b00;
            stall--;
        end else begin
            bus.o_fifo_rdy = alt ? 2'b10 : 2'b01;
        end
        prev_read = bus.o_read;
        prev_act  = bus.o_fifo_act;
        prev_rdy  = bus.o_fifo_rdy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] exp_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input bit last);
`ifdef NH_LCD_READER_BGR_EN
        return {last, b2, b1, b0};
`else
        return {last, b0, b1, b2};
`endif
    endfunction

    task automatic clear_mon();
        panel_q.delete();
        got_q.delete();
        grab_q.delete();
        read_rises = 0; read_noact = 0; writes = 0; dones = 0; strobes_grab = 0;
        viol_len = 0; viol_gap = 0; viol_stb = 0; viol_act = 0; viol_sel = 0; viol_cmd = 0; viol_en = 0;
        alt = 1'b0; stall = 0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int sz,
                             input int mode, input logic [1:0] fixed, input bit seq_bytes,
                             input int abort_at);
        logic [7:0] bytes[$];
        logic [7:0] b;
        int npix, rem, cyc, g, ngot;
        clear_mon();
        rdy_mode = mode;
        rdy_fixed = fixed;
        bus.i_fifo_size = 24'(sz);
        width = 32'(w);
        height = 32'(h);
        npix = (abort_at > 0) ? ((abort_at - 1) / 3 + 1) : w * h;
        panel_q.push_back(8'hFF);
        for (int i = 0; i < 3 * w * h; i++) begin
            b = seq_bytes ? 8'((i + 1) * 17) : 8'($urandom);
            bytes.push_back(b);
            panel_q.push_back(b);
        end
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < 3000) begin
            start = (cyc == 10);
            if (abort_at > 0 && read_rises >= abort_at) enable = 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_timeout"}, 32'(busy), 32'd0);
        enable = 1'b1;
        tick(); tick();
        check({tag, "_strobes"}, 32'(got_q.size()), 32'(npix));
        ngot = (got_q.size() < npix) ? got_q.size() : npix;
        for (int p = 0; p < ngot; p++)
            check({tag, "_pixel"}, 32'(got_q[p]),
                  32'(exp_word(bytes[3*p], bytes[3*p+1], bytes[3*p+2], (p % w) == w - 1)));
        check({tag, "_dones"}, 32'(dones), (abort_at > 0) ? 32'd0 : 32'd1);
        check({tag, "_cmd_writes"}, 32'(writes), 32'd1);
        check({tag, "_read_bytes"}, 32'(read_rises), 32'(1 + 3 * npix));
        check({tag, "_reads_without_act"}, 32'(read_noact), 32'd1);
        check({tag, "_bus_rules"}, 32'(viol_len + viol_gap + viol_stb + viol_act + viol_sel + viol_cmd + viol_en), 32'd0);
        rem = npix;
        g = 0;
        while (rem > 0) begin
            if (g < grab_q.size())
                check({tag, "_grab_len"}, 32'(grab_q[g]), 32'((rem < sz) ? rem : sz));
            rem -= (rem < sz) ? rem : sz;
            g++;
        end
        check({tag, "_grab_count"}, 32'(grab_q.size()), 32'(g));
        check({tag, "_act_idle"}, 32'(bus.o_fifo_act), 32'd0);
        check({tag, "_en_idle"}, 32'(bus.o_data_out_en), 32'd1);
    endtask

    initial begin
        bit seen;
        int cyc;
        rst = 1'b1; enable = 1'b1; start = 1'b0;
        width = 32'd0; height = 32'd0;
        bus.i_fifo_size = 24'd16;
        tick(); tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_act", 32'(bus.o_fifo_act), 32'd0);
        check("rst_stb", 32'(bus.o_fifo_stb), 32'd0);
        check("rst_data", 32'(bus.o_fifo_data), 32'd0);
        check("rst_cmd_mode", 32'(bus.o_cmd_mode), 32'd1);
        check("rst_data_out", 32'(bus.o_data_out), 32'h2E);
        check("rst_write", 32'(bus.o_write), 32'd0);
        check("rst_read", 32'(bus.o_read), 32'd0);
        check("rst_en", 32'(bus.o_data_out_en), 32'd1);
        rst = 1'b0;
        tick();

        run_frame("basic", 2, 2, 16, 0, 2'b01, 1'b1, 0);
        run_frame("split", 5, 1, 2, 1, 2'b00, 1'b0, 0);

        // Zero-sized frame finishes without touching the bus.
        clear_mon();
        width = 32'd0; height = 32'd4;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        seen = done;
        if (!seen) begin
            tick();
            seen = done;
        end
        check("zero_done_seen", 32'(seen), 32'd1);
        tick(); tick(); tick();
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_dones", 32'(dones), 32'd1);
        check("zero_writes", 32'(writes), 32'd0);
        check("zero_reads", 32'(read_rises), 32'd0);

        // Reset while the green byte is being read.
        clear_mon();
        rdy_mode = 0; rdy_fixed = 2'b01;
        width = 32'd3; height = 32'd1; bus.i_fifo_size = 24'd16;
        panel_q.push_back(8'hFF);
        for (int i = 0; i < 9; i++) panel_q.push_back(8'($urandom));
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        cyc = 0;
        while (read_rises < 3 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("rstmid_reach_g", 32'(read_rises), 32'd3);
        check("rstmid_read_hi", 32'(bus.o_read), 32'd1);
        rst = 1'b1;
        tick();
        check("rstmid_read", 32'(bus.o_read), 32'd0);
        check("rstmid_act", 32'(bus.o_fifo_act), 32'd0);
        check("rstmid_en", 32'(bus.o_data_out_en), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_stb", 32'(got_q.size()), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("rstmid_no_strobe_after", 32'(got_q.size()), 32'd0);

        run_frame("abort", 4, 2, 16, 0, 2'b01, 1'b0, 6);

        for (int k = 0; k < 4; k++)
            run_frame("rand", int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 4)), int'($urandom_range(0, 1)),
                      2'(1 + $urandom_range(0, 2)), 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
